// File: rtl/cr_controller_pkg.sv
//----------------------------------------------------------------------------
//  Module   : cr_controller_pkg
//  Purpose  : Shared traffic definitions. Lamp encodings are common to the
//             highway and country-road controllers; state encodings belong
//             to cr_controller.
//  Revision : 1.0  initial release
//----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package cr_controller_pkg;

   // One-hot lamp encodings shared with the highway controller
   localparam logic [2:0] c_led_green  = 3'b100;
   localparam logic [2:0] c_led_yellow = 3'b010;
   localparam logic [2:0] c_led_red    = 3'b001;

   // Country-road controller state encodings
   localparam int unsigned c_state_w   = 3;
   localparam logic [2:0] c_st_idle    = 3'd0;
   localparam logic [2:0] c_st_green   = 3'd1;
   localparam logic [2:0] c_st_yellow  = 3'd2;
   localparam logic [2:0] c_st_clear   = 3'd3;
   localparam logic [2:0] c_st_done    = 3'd4;

endpackage

`default_nettype wire

// File: rtl/cr_controller_phase_timer.sv
//----------------------------------------------------------------------------
//  Module   : phase_timer
//  Purpose  : 8-bit phase counter. Returns to zero on the edge at which the
//             owning FSM changes state, otherwise counts up and saturates at
//             255 so it never wraps inside a long state.
//  Revision : 1.0  initial release
//----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module phase_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_clear,
   output logic [7:0] o_cnt
);

   logic [7:0] r_cnt;

   // Count cycles spent in the current state; clear when the state changes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= 8'd0;
      end else if (i_clear) begin
         r_cnt <= 8'd0;
      end else if (r_cnt != 8'hFF) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/cr_controller.sv
//----------------------------------------------------------------------------
//  Module   : cr_controller
//  Purpose  : Country-road lamp sequencer. Grants green on request from the
//             highway side, holds it between GREEN_MIN and GREEN_MAX cycles
//             depending on vehicle presence, then yellow and an all-red
//             clearance before handing back via a four-phase handshake.
//  Revision : 1.0  initial release
//----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module cr_controller
   import cr_controller_pkg::*;
#(
   parameter int GREEN_MIN = 4,
   parameter int GREEN_MAX = 10,
   parameter int YELLOW_T  = 3,
   parameter int ALL_RED   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       CR_Ena,
   input  logic       sensor,
   output logic [2:0] CR_LED,
   output logic       CR_Done
);

   // Reject illegal timing parameters at elaboration
   generate
      if (GREEN_MIN < 1 || GREEN_MIN > GREEN_MAX || GREEN_MAX > 255 ||
          YELLOW_T < 1 || YELLOW_T > 255 || ALL_RED < 1 || ALL_RED > 255) begin : g_bad_params
         $error("cr_controller: illegal timing parameters");
      end
   endgenerate

   // Terminal counts, expressed in the 8-bit counter domain
   localparam logic [7:0] c_green_min_m1 = 8'(GREEN_MIN - 1);
   localparam logic [7:0] c_green_max_m1 = 8'(GREEN_MAX - 1);
   localparam logic [7:0] c_yellow_m1    = 8'(YELLOW_T - 1);
   localparam logic [7:0] c_all_red_m1   = 8'(ALL_RED - 1);

   logic [c_state_w-1:0] r_state;
   logic [c_state_w-1:0] w_next_state;
   logic                 w_state_change;
   logic [7:0]           w_cnt;

   assign w_state_change = (w_next_state != r_state);

   phase_timer u_phase_timer (
      .clk     (clk),
      .rst     (rst),
      .i_clear (w_state_change),
      .o_cnt   (w_cnt)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; any unused encoding falls back to IDLE
   always_comb begin
      w_next_state = c_st_idle;
      case (r_state)
         c_st_idle: begin
            w_next_state = CR_Ena ? c_st_green : c_st_idle;
         end
         c_st_green: begin
            // Sensor is only looked at once the minimum green has elapsed
            if ((w_cnt == c_green_max_m1) ||
                ((w_cnt >= c_green_min_m1) && !sensor)) begin
               w_next_state = c_st_yellow;
            end else begin
               w_next_state = c_st_green;
            end
         end
         c_st_yellow: begin
            w_next_state = (w_cnt == c_yellow_m1) ? c_st_clear : c_st_yellow;
         end
         c_st_clear: begin
            w_next_state = (w_cnt == c_all_red_m1) ? c_st_done : c_st_clear;
         end
         c_st_done: begin
            // Hold until the highway side withdraws its request
            w_next_state = CR_Ena ? c_st_done : c_st_idle;
         end
         default: begin
            w_next_state = c_st_idle;
         end
      endcase
   end

   // Output decode from the registered state only
   always_comb begin
      CR_LED  = c_led_red;
      CR_Done = 1'b0;
      case (r_state)
         c_st_green:  CR_LED  = c_led_green;
         c_st_yellow: CR_LED  = c_led_yellow;
         c_st_done:   CR_Done = 1'b1;
         default:     CR_LED  = c_led_red;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_cr_controller.sv
//----------------------------------------------------------------------------
//  Module   : tb_cr_controller
//  Purpose  : Directed self-checking bench for cr_controller (default
//             parameters). Cycle n is the period between edge n-1 and edge
//             n, where edge 0 is the first edge sampling CR_Ena=1.
//  Revision : 1.0  initial release
//----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_cr_controller;

   localparam logic [2:0] c_g = 3'b100;
   localparam logic [2:0] c_y = 3'b010;
   localparam logic [2:0] c_r = 3'b001;

   logic       clk    = 1'b0;
   logic       rst    = 1'b1;
   logic       CR_Ena = 1'b0;
   logic       sensor = 1'b1;
   logic [2:0] CR_LED;
   logic       CR_Done;

   int checks   = 0;
   int failures = 0;

   cr_controller #(
      .GREEN_MIN (4),
      .GREEN_MAX (10),
      .YELLOW_T  (3),
      .ALL_RED   (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .CR_Ena  (CR_Ena),
      .sensor  (sensor),
      .CR_LED  (CR_LED),
      .CR_Done (CR_Done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic sens_at(int c, int lo, int hi);
      return (c >= lo && c <= hi) ? 1'b0 : 1'b1;
   endfunction

   // Starts a request from IDLE and checks every cycle against hand-derived
   // phase boundaries: green 1..g_last, yellow ..y_last, clear ..c_last,
   // done ..d_last, then idle until total.
   task automatic run_scn(input string name, input int ena_low_at,
                          input int s_lo, input int s_hi,
                          input int g_last, input int y_last, input int c_last,
                          input int d_last, input int total);
      logic [2:0] e_led;
      logic       e_done;
      CR_Ena = 1'b1;
      sensor = sens_at(0, s_lo, s_hi);
      step();
      for (int c = 1; c <= total; c++) begin
         if (c <= g_last)      begin e_led = c_g; e_done = 1'b0; end
         else if (c <= y_last) begin e_led = c_y; e_done = 1'b0; end
         else if (c <= c_last) begin e_led = c_r; e_done = 1'b0; end
         else if (c <= d_last) begin e_led = c_r; e_done = 1'b1; end
         else                  begin e_led = c_r; e_done = 1'b0; end
         check($sformatf("%s_c%0d_led", name, c), {5'd0, CR_LED}, {5'd0, e_led});
         check($sformatf("%s_c%0d_done", name, c), {7'd0, CR_Done}, {7'd0, e_done});
         CR_Ena = (c >= ena_low_at) ? 1'b0 : 1'b1;
         sensor = sens_at(c, s_lo, s_hi);
         step();
      end
   endtask

   initial begin
      // Reset held, then idle with no request for 20 cycles
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_led", {5'd0, CR_LED}, {5'd0, c_r});
         check("rst_done", {7'd0, CR_Done}, 8'd0);
      end
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         check($sformatf("idle_%0d_led", i), {5'd0, CR_LED}, {5'd0, c_r});
         check($sformatf("idle_%0d_done", i), {7'd0, CR_Done}, 8'd0);
      end

      // Sensor always present: full green, request dropped at cycle 20
      run_scn("max",      20, -1, -2, 10, 13, 15, 20, 23);
      // No vehicle: minimum green only
      run_scn("min",      12, 0, 100000, 4, 7, 9, 12, 14);
      // Request withdrawn early: sequence completes, single-cycle DONE
      run_scn("early",     3, -1, -2, 10, 13, 15, 16, 19);
      // Sensor glitch before minimum green has no effect
      run_scn("glitch",   18, 1, 2, 10, 13, 15, 18, 20);
      // Vehicle leaves at cycle 5, after minimum green
      run_scn("leave",    12, 5, 100000, 5, 8, 10, 12, 14);

      // Asynchronous reset mid-yellow, request still high
      CR_Ena = 1'b1;
      sensor = 1'b1;
      step();
      for (int c = 1; c < 12; c++) step();
      check("ar_pre_led", {5'd0, CR_LED}, {5'd0, c_y});
      #2 rst = 1'b1;
      #1;
      check("ar_async_led", {5'd0, CR_LED}, {5'd0, c_r});
      check("ar_async_done", {7'd0, CR_Done}, 8'd0);
      @(posedge clk);
      #3 rst = 1'b0;
      check("ar_held_led", {5'd0, CR_LED}, {5'd0, c_r});
      for (int c = 1; c <= 10; c++) begin
         step();
         check($sformatf("ar_green_%0d", c), {5'd0, CR_LED}, {5'd0, c_g});
      end
      step();
      check("ar_yellow", {5'd0, CR_LED}, {5'd0, c_y});
      for (int c = 0; c < 5; c++) step();
      check("ar_done", {7'd0, CR_Done}, 8'd1);

      // Asynchronous reset during DONE
      #2 rst = 1'b1;
      #1;
      check("ar_done_clr", {7'd0, CR_Done}, 8'd0);
      CR_Ena = 1'b0;
      @(posedge clk);
      #3 rst = 1'b0;
      step();
      check("ar_idle_led", {5'd0, CR_LED}, {5'd0, c_r});
      check("ar_idle_done", {7'd0, CR_Done}, 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/cr_controller.md
CR_CONTROLLER -- requirements
Module: cr_controller

Interface
REQ-001 The clock port SHALL be clk, input, 1 bit, sampled on the rising edge.
REQ-002 The reset port SHALL be rst, input, 1 bit, asynchronous and active-high.
REQ-003 CR_Ena SHALL be an input, 1 bit: the highway side's request for country-road right-of-way, held high until CR_Done is seen.
REQ-004 sensor SHALL be an input, 1 bit: a vehicle is present on the country road.
REQ-005 CR_LED SHALL be an output, 3 bits: country-road lamps, one-hot; 100 green, 010 yellow, 001 red.
REQ-006 CR_Done SHALL be an output, 1 bit: the country-road cycle is complete and the road is red again.
REQ-007 Parameter GREEN_MIN, default 4: minimum green time, in cycles.
REQ-008 Parameter GREEN_MAX, default 10: maximum green time, in cycles.
REQ-009 Parameter YELLOW_T, default 3: yellow time, in cycles.
REQ-010 Parameter ALL_RED, default 2: red clearance time before CR_Done, in cycles.
REQ-011 Parameter legality SHALL be 1 <= GREEN_MIN <= GREEN_MAX <= 255, with YELLOW_T and ALL_RED each in 1..255; violation is an elaboration error.

Function
REQ-012 The FSM SHALL have five states: IDLE, GREEN, YELLOW, CLEAR, DONE.
REQ-013 CR_LED SHALL be 001 in IDLE, CLEAR and DONE; 100 in GREEN; 010 in YELLOW.
REQ-014 CR_Done SHALL be 1 only in DONE; all outputs SHALL be registered, or decoded from registered state only.
REQ-015 An 8-bit phase counter cnt SHALL be 0 in the first cycle of every state and increment by 1 each cycle; it SHALL NOT wrap within a state.
REQ-016 IDLE -> GREEN SHALL occur on the edge at which CR_Ena=1 is sampled; with CR_Ena=0 the block SHALL stay in IDLE.
REQ-017 GREEN -> YELLOW SHALL occur at the end of the cycle in which either condition holds:
- cnt == GREEN_MAX-1, or
- cnt >= GREEN_MIN-1 and sensor == 0.
REQ-018 YELLOW -> CLEAR SHALL occur when cnt == YELLOW_T-1.
REQ-019 CLEAR -> DONE SHALL occur when cnt == ALL_RED-1.
REQ-020 DONE -> IDLE SHALL occur on the first edge with CR_Ena=0 (four-phase handshake); DONE SHALL last at least 1 cycle.
REQ-021 CR_Ena falling during GREEN, YELLOW or CLEAR SHALL be ignored: the sequence completes and DONE lasts exactly 1 cycle.
REQ-022 Sensor glitches before cnt reaches GREEN_MIN-1 SHALL have no effect.
REQ-023 GREEN_MIN == GREEN_MAX SHALL give a fixed green time regardless of sensor.
REQ-024 Unreachable state encodings SHALL recover to IDLE on the next edge.

Reset
REQ-025 While rst=1, at any point in the cycle including mid-sequence: state=IDLE, cnt=0, CR_LED=001, CR_Done=0, immediately and asynchronously.
REQ-026 After rst deasserts, the first transition SHALL be evaluated on the next rising clk edge.

Structure
REQ-027 The shared traffic package/include SHALL hold:
- the LED encodings (GREEN 100, YELLOW 010, RED 001), shared with the highway controller;
- the cr_controller state encodings.
REQ-028 One sub-module, phase_timer, SHALL be used: an 8-bit counter with synchronous clear-on-state-change and asynchronous rst. The FSM and output decode stay in cr_controller.

Verification (defaults, cycle 0 = first edge with CR_Ena=1)
REQ-029 Reset with CR_Ena=0 for 20 cycles -> CR_LED=001 and CR_Done=0 throughout.
REQ-030 CR_Ena held high, sensor=1 -> green cycles 1-10, yellow 11-13, red clear 14-15, CR_Done=1 from cycle 16; CR_Ena dropped at cycle 20 -> IDLE at cycle 21.
REQ-031 sensor=0 throughout -> green lasts exactly 4 cycles (1-4), yellow 5-7, CR_Done=1 at cycle 10.
REQ-032 CR_Ena low at cycle 3 -> full sequence completes, CR_Done=1 for exactly cycle 16, IDLE at cycle 17.
REQ-033 rst pulsed at cycle 12 (mid-yellow) -> CR_LED=001 and CR_Done=0 within the same cycle; CR_Ena still high -> green restarts on the first edge after release.
REQ-034 sensor=0 for cycles 1-2, then 1 -> green extends to GREEN_MAX (cycles 1-10).
